// File: rtl/irq_request_gen_pkg.sv
// Shared types for the external-interrupt requester: per-channel request FSM state encoding.
package irq_request_gen_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_REQ   = 2'd1,
        IRQ_HOLD  = 2'd2,
        IRQ_REARM = 2'd3
    } irq_state_e;

endpackage

// File: rtl/irq_debounce.sv
// One button channel: 2-FF synchroniser, stability counter, accepted level db and its rising-edge pulse.
module irq_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic in_RST,
    input  logic btn_raw,
    output logic db,
    output logic rise
);

    logic [1:0]       sync_ff;
    logic [CNT_W-1:0] cnt;
    logic             db_q;
    logic             s;

    assign s    = sync_ff[1];
    assign rise = db & ~db_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!in_RST) begin
            sync_ff <= '0;
            cnt     <= '0;
            db      <= 1'b0;
            db_q    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], btn_raw};
            db_q    <= db;
            if (s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // Counter is cleared at its terminal value, so it never wraps.
                db  <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/irq_request_gen.sv
// Requester side of the CPU external-interrupt interface: debounced buttons become level requests
// held until granted; presses arriving while a request is pending are flagged in lost[].
module irq_request_gen
    import irq_request_gen_pkg::*;
#(
    parameter int NUM_IRQ         = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               in_RST,
    input  logic [NUM_IRQ-1:0] btn_raw,
    input  logic [NUM_IRQ-1:0] IG,
    input  logic               clr_lost,
    output logic [NUM_IRQ-1:0] in_IR,
    output logic [NUM_IRQ-1:0] lost,
    output logic               busy
);

    logic [NUM_IRQ-1:0] db;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] ig_q;
    logic [NUM_IRQ-1:0] ig_edge;
    irq_state_e         state [NUM_IRQ];

    // A grant held high for several cycles acts only on its first cycle.
    assign ig_edge = IG & ~ig_q;
    assign busy    = |in_IR;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ch
        irq_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk     (clk),
            .in_RST  (in_RST),
            .btn_raw (btn_raw[g]),
            .db      (db[g]),
            .rise    (rise[g])
        );

        assign in_IR[g] = (state[g] == IRQ_REQ);
    end

    always_ff @(posedge clk) begin
        if (!in_RST) begin
            ig_q <= '0;
            lost <= '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                state[i] <= IRQ_IDLE;
            end
        end else begin
            ig_q <= IG;
            for (int i = 0; i < NUM_IRQ; i++) begin
                // A new press on a pending request sets lost, overriding a same-cycle clear.
                lost[i] <= (lost[i] & ~clr_lost)
                         | ((state[i] == IRQ_REQ) & rise[i] & ~ig_edge[i]);
                case (state[i])
                    IRQ_IDLE: begin
                        if (rise[i]) state[i] <= IRQ_REQ;
                    end
                    IRQ_REQ: begin
                        if (ig_edge[i]) begin
                            if (rise[i])    state[i] <= IRQ_REARM;
                            else if (db[i]) state[i] <= IRQ_HOLD;
                            else            state[i] <= IRQ_IDLE;
                        end
                    end
                    IRQ_HOLD: begin
                        if (!db[i]) state[i] <= IRQ_IDLE;
                    end
                    IRQ_REARM: begin
                        // One low cycle gives the interrupt unit a falling edge before re-requesting.
                        state[i] <= IRQ_REQ;
                    end
                    default: state[i] <= IRQ_IDLE;
                endcase
            end
        end
    end

endmodule
